// File: rtl/regfile_write_scheduler.sv
// Write-port scheduler for the 32-entry register file: round-robin arbitration
// between two writeback requesters plus a clear sequencer for registers 1..N-1.
module regfile_write_scheduler #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  clear_start,
  output logic                  busy,
  output logic                  wrenable,
  output logic [ADDR_WIDTH-1:0] writeaddr,
  output logic [DATA_WIDTH-1:0] writedata
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state, state_d;
  logic                  rr_ptr, rr_ptr_d;
  logic [ADDR_WIDTH-1:0] counter, counter_d;
  logic                  busy_d, wrenable_d;
  logic [ADDR_WIDTH-1:0] writeaddr_d;
  logic [DATA_WIDTH-1:0] writedata_d;

  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    counter_d   = counter;
    busy_d      = busy;
    wrenable_d  = 1'b0;
    writeaddr_d = writeaddr;
    writedata_d = writedata;

    if (state == IDLE) begin
      if (clear_start) begin
        state_d   = CLEAR;
        counter_d = ADDR_WIDTH'(1);
        busy_d    = 1'b1;
      end else begin
        // rr_ptr == 0 favours requester 0 when both are valid
        if (req0_valid && (!req1_valid || !rr_ptr))
          req0_ready = 1'b1;
        else if (req1_valid)
          req1_ready = 1'b1;

        // Address 0 is accepted but dropped, like the hardwired-zero cell
        if (req0_ready) begin
          rr_ptr_d = 1'b1;
          if (req0_addr != '0) begin
            wrenable_d  = 1'b1;
            writeaddr_d = req0_addr;
            writedata_d = req0_data;
          end
        end else if (req1_ready) begin
          rr_ptr_d = 1'b0;
          if (req1_addr != '0) begin
            wrenable_d  = 1'b1;
            writeaddr_d = req1_addr;
            writedata_d = req1_data;
          end
        end
      end
    end else begin
      wrenable_d  = 1'b1;
      writeaddr_d = counter;
      writedata_d = '0;
      counter_d   = counter + ADDR_WIDTH'(1);
      if (counter == LAST_ADDR) begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        counter_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      counter   <= '0;
      busy      <= 1'b0;
      wrenable  <= 1'b0;
      writeaddr <= '0;
      writedata <= '0;
    end else begin
      state     <= state_d;
      rr_ptr    <= rr_ptr_d;
      counter   <= counter_d;
      busy      <= busy_d;
      wrenable  <= wrenable_d;
      writeaddr <= writeaddr_d;
      writedata <= writedata_d;
    end
  end

endmodule
